// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state codes, parity types, line levels.
package fifo_uart_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic LVL_START = 1'b0;
   localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle (first-word-fall-through) between the async FIFO and its reader.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  FIFO_EMPTY;
   logic [DATA_WIDTH-1:0] RD_DATA;
   logic                  R_INC;

   // FIFO side presents the head word and consumes pop strobes
   modport master (
      output FIFO_EMPTY,
      output RD_DATA,
      input  R_INC
   );

   // Reader side watches the head word and issues pop strobes
   modport slave (
      input  FIFO_EMPTY,
      input  RD_DATA,
      output R_INC
   );

endinterface

// File: rtl/fifo_uart_tx_parity_calc.sv
// Combinational UART parity bit for a data word; shared with the RX parity checker.
module uart_tx_parity_calc
   import fifo_uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   // Even parity makes the total count of ones even; odd parity inverts it
   always_comb begin
      par_bit = ^data;
      case (par_typ)
         PAR_EVEN: par_bit = ^data;
         PAR_ODD:  par_bit = ~(^data);
      endcase
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter popping bytes from a FWFT FIFO read port and serialising
// them as start / data (LSB first) / optional parity / stop frames.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   fifo_uart_tx_if.slave         fifo,
   input  logic                  TX_EN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FRAME_DONE
);

   import fifo_uart_tx_pkg::*;

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]      ONE_I    = IDX_W'(1);
   localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);

   logic [2:0]            state;
   logic [PRESCALE_W-1:0] bit_cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] data_cap;
   logic                  par_en_cap;
   logic                  par_typ_cap;
   logic [PRESCALE_W-1:0] per_bit;
   logic [PRESCALE_W-1:0] last_cnt;
   logic [PRESCALE_W-1:0] eff_prescale;
   logic                  par_bit;
   logic                  start_ok;
   logic                  bit_end;
   logic                  load;

   // PRESCALE of 0 behaves like 1 so every bit lasts at least one cycle
   assign eff_prescale = (PRESCALE <= ONE_P) ? ONE_P : PRESCALE;
   assign last_cnt     = per_bit - ONE_P;
   assign bit_end      = (bit_cnt == last_cnt);
   assign start_ok     = TX_EN && !fifo.FIFO_EMPTY;

   // A new frame begins from IDLE or directly from the final stop cycle
   assign load = start_ok && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   uart_tx_parity_calc #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_parity (
      .data    (data_cap),
      .par_typ (par_typ_cap),
      .par_bit (par_bit)
   );

   // Capture the head word and frame configuration at pop time; shift data out LSB first
   always_ff @(posedge CLK) begin
      if (load) begin
         shift       <= fifo.RD_DATA;
         data_cap    <= fifo.RD_DATA;
         par_en_cap  <= PAR_EN;
         par_typ_cap <= PAR_TYP;
         per_bit     <= eff_prescale;
      end else if (bit_end && ((state == ST_START) || (state == ST_DATA))) begin
         shift <= shift >> 1;
      end
   end

   // Frame sequencer: bit timing, state transitions and registered line/status outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         TX_OUT     <= LVL_STOP;
         fifo.R_INC <= 1'b0;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         fifo.R_INC <= 1'b0;
         FRAME_DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  state      <= ST_START;
                  bit_cnt    <= '0;
                  fifo.R_INC <= 1'b1;
                  TX_OUT     <= LVL_START;
                  BUSY       <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  TX_OUT  <= shift[0];
               end else begin
                  bit_cnt <= bit_cnt + ONE_P;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (bit_idx == LAST_IDX) begin
                     if (par_en_cap) begin
                        state  <= ST_PARITY;
                        TX_OUT <= par_bit;
                     end else begin
                        state      <= ST_STOP;
                        TX_OUT     <= LVL_STOP;
                        FRAME_DONE <= (per_bit == ONE_P);
                     end
                  end else begin
                     bit_idx <= bit_idx + ONE_I;
                     TX_OUT  <= shift[0];
                  end
               end else begin
                  bit_cnt <= bit_cnt + ONE_P;
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state      <= ST_STOP;
                  bit_cnt    <= '0;
                  TX_OUT     <= LVL_STOP;
                  FRAME_DONE <= (per_bit == ONE_P);
               end else begin
                  bit_cnt <= bit_cnt + ONE_P;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (start_ok) begin
                     state      <= ST_START;
                     fifo.R_INC <= 1'b1;
                     TX_OUT     <= LVL_START;
                  end else begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                  end
               end else begin
                  bit_cnt    <= bit_cnt + ONE_P;
                  FRAME_DONE <= ((bit_cnt + ONE_P) == last_cnt);
               end
            end
            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               TX_OUT  <= LVL_STOP;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds the DUT, every queued
// byte pushes an expected frame, and a monitor checks the line cycle by cycle.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          TX_EN;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic [PW-1:0] PRESCALE;
   logic          TX_OUT;
   logic          BUSY;
   logic          FRAME_DONE;

   fifo_uart_tx_if #(.DATA_WIDTH(DW)) fifo_bus ();

   fifo_uart_tx #(
      .DATA_WIDTH(DW),
      .PRESCALE_W(PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .fifo       (fifo_bus),
      .TX_EN      (TX_EN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .PRESCALE   (PRESCALE),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY),
      .FRAME_DONE (FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      bit         par_en;
      bit         par_typ;
      int         p;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] fifo_q[$];
   int         rinc_cyc[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   int         n_pops = 0;
   int         cyc    = 0;
   bit         mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Queue a byte in the FIFO model and the frame the current config implies
   task automatic send(input logic [7:0] d);
      frame_t f;
      f.data    = d;
      f.par_en  = PAR_EN;
      f.par_typ = PAR_TYP;
      f.p       = int'(PRESCALE);
      exp_q.push_back(f);
      fifo_q.push_back(d);
   endtask

   task automatic wait_rinc(input string name, input int limit);
      for (int i = 0; i < limit; i++) begin
         tick();
         if (fifo_bus.R_INC === 1'b1) break;
      end
      check(name, 32'(fifo_bus.R_INC), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int limit);
      for (int i = 0; i < limit; i++) begin
         tick();
         if (BUSY === 1'b0 && fifo_bus.R_INC === 1'b0 && fifo_q.size() == 0 && exp_q.size() == 0) break;
      end
      check(name, 32'({BUSY, (fifo_q.size() != 0)}), 32'd0);
   endtask

   // Record n line cycles starting with the current one
   task automatic grab(input int n, output logic [15:0] seq, output int fd_pos);
      seq    = '0;
      fd_pos = -1;
      for (int i = 0; i < n; i++) begin
         seq[i] = TX_OUT;
         if (FRAME_DONE === 1'b1 && fd_pos < 0) fd_pos = i;
         if (i < n - 1) tick();
      end
   endtask

   // FIFO model: FWFT head word, popped when the DUT strobes R_INC
   initial begin
      fifo_bus.FIFO_EMPTY = 1'b1;
      fifo_bus.RD_DATA    = '0;
      forever begin
         @(negedge CLK);
         if (fifo_bus.R_INC === 1'b1) begin
            check("pop_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) begin
               void'(fifo_q.pop_front());
               n_pops++;
            end
         end
         fifo_bus.FIFO_EMPTY = (fifo_q.size() == 0);
         fifo_bus.RD_DATA    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
   end

   // Monitor: expand each expected frame into line levels and compare every cycle
   initial begin
      frame_t     f;
      bit         bits[$];
      int         k;
      int         total;
      int         pe;
      bit         in_frame;
      logic [3:0] expv;
      in_frame = 1'b0;
      k = 0; total = 0; pe = 1;
      forever begin
         @(negedge CLK);
         cyc++;
         if (mon_en) begin
            if (!in_frame && fifo_bus.R_INC === 1'b1) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_pop: actual=R_INC high required=no pending frame (t=%0t)", $time);
               end else begin
                  f  = exp_q.pop_front();
                  pe = (f.p <= 1) ? 1 : f.p;
                  bits.delete();
                  bits.push_back(1'b0);
                  for (int i = 0; i < DW; i++) bits.push_back(f.data[i]);
                  if (f.par_en) bits.push_back(bit'(($countones(f.data) % 2) == 1) ^ f.par_typ);
                  bits.push_back(1'b1);
                  total    = pe * bits.size();
                  k        = 0;
                  in_frame = 1'b1;
                  rinc_cyc.push_back(cyc);
               end
            end
            if (in_frame) begin
               expv = {bits[k / pe], 1'b1, logic'(k == 0), logic'(k == total - 1)};
               check("frame_cycle{tx,busy,rinc,done}", 32'({TX_OUT, BUSY, fifo_bus.R_INC, FRAME_DONE}), 32'(expv));
               k++;
               if (k == total) in_frame = 1'b0;
            end else begin
               check("idle_cycle{tx,busy,rinc,done}", 32'({TX_OUT, BUSY, fifo_bus.R_INC, FRAME_DONE}), 32'h8);
            end
            if (RST === 1'b1) in_frame = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=time limit reached required=bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] seq;
      int          fd;
      int          pops0;
      int          b;
      int          n;

      RST      = 1'b1;
      TX_EN    = 1'b0;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      PRESCALE = PW'(1);
      repeat (3) tick();
      check("rst_tx_out", 32'(TX_OUT), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_r_inc", 32'(fifo_bus.R_INC), 32'd0);
      check("rst_frame_done", 32'(FRAME_DONE), 32'd0);
      RST    = 1'b0;
      mon_en = 1'b1;
      tick();

      // Reset during DATA bit 3 of 0xA5
      TX_EN = 1'b1;
      send(8'hA5);
      wait_rinc("g_pop", 20);
      repeat (4) tick();
      check("g_bit3_level", 32'(TX_OUT), 32'd0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("g_tx_after_rst", 32'(TX_OUT), 32'd1);
      check("g_busy_after_rst", 32'(BUSY), 32'd0);
      check("g_rinc_after_rst", 32'(fifo_bus.R_INC), 32'd0);
      pops0 = n_pops;
      repeat (20) tick();
      check("g_no_pop_when_empty", 32'(n_pops - pops0), 32'd0);

      // P=1, no parity, 0xA5
      pops0 = n_pops;
      send(8'hA5);
      wait_rinc("a_pop", 20);
      grab(10, seq, fd);
      check("a_tx_sequence", 32'(seq[9:0]), 32'h34A);
      check("a_done_position", 32'(fd), 32'd9);
      tick();
      check("a_busy_falls", 32'(BUSY), 32'd0);
      check("a_single_pop", 32'(n_pops - pops0), 32'd1);
      wait_idle("a_idle", 50);

      // P=1, parity even then odd, 0xA5
      PAR_EN  = 1'b1;
      PAR_TYP = 1'b0;
      send(8'hA5);
      wait_rinc("b_even_pop", 20);
      grab(11, seq, fd);
      check("b_even_parity_bit", 32'(seq[9]), 32'd0);
      check("b_even_done_pos", 32'(fd), 32'd10);
      wait_idle("b_even_idle", 50);
      PAR_TYP = 1'b1;
      send(8'hA5);
      wait_rinc("b_odd_pop", 20);
      grab(11, seq, fd);
      check("b_odd_parity_bit", 32'(seq[9]), 32'd1);
      check("b_odd_done_pos", 32'(fd), 32'd10);
      wait_idle("b_odd_idle", 50);

      // P=4, two back-to-back words
      PAR_EN   = 1'b0;
      PRESCALE = PW'(4);
      rinc_cyc.delete();
      send(8'h3C);
      send(8'hFF);
      wait_idle("c_idle", 200);
      check("c_pop_count", 32'(rinc_cyc.size()), 32'd2);
      if (rinc_cyc.size() >= 2) check("c_pop_spacing", 32'(rinc_cyc[1] - rinc_cyc[0]), 32'd40);

      // TX_EN dropped mid-frame with two words queued
      PRESCALE = PW'(1);
      pops0 = n_pops;
      send(8'h11);
      send(8'h22);
      wait_rinc("d_pop", 20);
      TX_EN = 1'b0;
      for (int i = 0; i < 50 && BUSY !== 1'b0; i++) tick();
      check("d_busy_low", 32'(BUSY), 32'd0);
      repeat (20) tick();
      check("d_one_pop_only", 32'(n_pops - pops0), 32'd1);
      check("d_word_left", 32'(fifo_q.size()), 32'd1);
      TX_EN = 1'b1;
      wait_rinc("d_restart_pop", 20);
      wait_idle("d_idle", 50);
      check("d_two_pops", 32'(n_pops - pops0), 32'd2);

      // PRESCALE 0 and 1 give identical single-cycle bits
      PRESCALE = PW'(0);
      send(8'h5A);
      wait_rinc("e_p0_pop", 20);
      grab(10, seq, fd);
      check("e_p0_sequence", 32'(seq[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
      check("e_p0_done_pos", 32'(fd), 32'd9);
      wait_idle("e_p0_idle", 50);
      PRESCALE = PW'(1);
      send(8'h5A);
      wait_rinc("e_p1_pop", 20);
      grab(10, seq, fd);
      check("e_p1_sequence", 32'(seq[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
      check("e_p1_done_pos", 32'(fd), 32'd9);
      wait_idle("e_p1_idle", 50);

      // PRESCALE changed 2 -> 8 mid-frame keeps the frame at P=2
      PRESCALE = PW'(2);
      send(8'hC3);
      wait_rinc("f_pop", 20);
      PRESCALE = PW'(8);
      n = 0;
      while (BUSY === 1'b1 && n < 200) begin
         n++;
         tick();
      end
      check("f_frame_length", 32'(n), 32'd20);
      wait_idle("f_idle", 50);

      // Randomised bursts under random configuration
      for (b = 0; b < 12; b++) begin
         PRESCALE = PW'($urandom_range(0, 6));
         PAR_EN   = 1'($urandom_range(0, 1));
         PAR_TYP  = 1'($urandom_range(0, 1));
         TX_EN    = 1'b1;
         n        = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
         wait_idle("rnd_idle", 800);
      end

      repeat (3) tick();
      check("exp_drained", 32'(exp_q.size()), 32'd0);
      check("fifo_drained", 32'(fifo_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
